// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and a data memory responder.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready on both the request and the response channels.
//
// Signals
//   req_valid/req_ready       : request handshake
//   req_we                    : 1 = store, 0 = load
//   req_addr                  : byte address
//   req_wdata                 : store data, right-aligned
//   req_funct3                : RV32I load/store width code
//   resp_valid/resp_ready     : response handshake
//   resp_rdata                : load result (0 for stores and errors)
//   resp_err                  : access rejected
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering RV32I byte/half/word loads and stores.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after the request is accepted.
// Backpressure: one access in flight; response held stable until resp_ready, req_ready low until then.
//
// Ports
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (storage array is not cleared)
//   bus   : data_mem_responder_if.slave (request + response channels)
// Build option
//   MISALIGN_CHECK_EN : when defined, misaligned halfword/word accesses return resp_err
//                       with no write; otherwise the low address bits are ignored.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          cap;
  logic          mem_we;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the word index are intentionally dropped so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:AW+2];

  // ---- access decode on the captured request ----
  logic        acc_err;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign rd_word = mem[idx_q];
  assign ld_byte = rd_word[8*off_q +: 8];
  assign ld_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    acc_err = 1'b0;
    if (we_q) begin
      acc_err = (f3_q > 3'd2);
    end else begin
      acc_err = (f3_q == 3'd3) || (f3_q == 3'd6) || (f3_q == 3'd7);
    end
`ifdef MISALIGN_CHECK_EN
    if ((f3_q[1:0] == 2'd1) && off_q[0]) acc_err = 1'b1;
    if ((f3_q[1:0] == 2'd2) && (off_q != 2'd0)) acc_err = 1'b1;
`endif
  end

  always_comb begin
    ld_data = rd_word;
    case (f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Read-modify-write merge: only the selected lanes take store data.
  always_comb begin
    wr_word = rd_word;
    case (f3_q[1:0])
      2'd0:    wr_word[8*off_q +: 8] = wdata_q[7:0];
      2'd1:    if (off_q[1]) wr_word[31:16] = wdata_q[15:0];
               else          wr_word[15:0]  = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  // ---- control FSM ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cap     = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && rdy_q) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
          cap     = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // The access happens on this edge; stores commit exactly here.
          state_d = RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'd0 : ld_data;
          mem_we  = we_q && !acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered so ready stays low during reset and on the response handshake edge.
  assign rdy_d = (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (cap) begin
        we_q    <= bus.req_we;
        idx_q   <= bus.req_addr[AW+1:2];
        off_q   <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
      end
    end
  end

  // Storage survives reset; mem_we is low whenever the FSM is held in IDLE by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wr_word;
  end

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model, expected-response queue,
// independent monitor checking data, error, latency, stability and handshake timing.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [DEPTH*4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hold_cnt = 0;
  bit          in_resp = 0;
  bit          hs_pending = 0;
  logic [31:0] held_rd;
  logic        held_err;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Byte-addressed reference: each access touches sz consecutive bytes.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int sz;
    int b;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    if (we) err = (f3 > 3'd2);
    else    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef MISALIGN_CHECK_EN
    if (sz == 2 && addr[0]) err = 1'b1;
    if (sz == 4 && addr[1:0] != 2'd0) err = 1'b1;
`endif
    rd = 32'd0;
    b = int'(addr % 32'(DEPTH*4));
    b = b - (b % sz);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[b+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[b+i];
        if (!f3[2] && sz < 4 && v[8*sz-1] == 1'b1)
          for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input bit expect_resp);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    if (expect_resp) begin
      model(we, addr, wd, f3, e.rdata, e.err);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble fields after the accept edge: the DUT must use its captured copy.
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
  endtask

  // Monitor: pops expectations on each new response and polices the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
      in_resp = 0;
      hs_pending = 0;
      bus.resp_ready = 1'b0;
    end else begin
      if (hs_pending) begin
        chk("resp_drop_after_hs", {31'd0, bus.resp_valid}, 32'd0);
        chk("req_ready_after_hs", {31'd0, bus.req_ready}, 32'd1);
        hs_pending = 0;
        in_resp = 0;
      end
      if (bus.resp_valid) begin
        if (!in_resp) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
            chk("resp_latency", 32'(cyc - e.acc), 32'(W + 1));
          end
          in_resp = 1;
          held_rd = bus.resp_rdata;
          held_err = bus.resp_err;
        end else begin
          chk("hold_rdata", bus.resp_rdata, held_rd);
          chk("hold_err", {31'd0, bus.resp_err}, {31'd0, held_err});
          chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        if (hold_cnt > 0) begin
          bus.resp_ready = 1'b0;
          hold_cnt--;
        end else begin
          bus.resp_ready = 1'($urandom_range(0, 1));
        end
        if (bus.resp_ready) hs_pending = 1;
      end else begin
        bus.resp_ready = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

    // Give every word a defined value.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i*4), $urandom, 3'b010, 1'b1);

    // Word store/load, byte store and sign/zero-extended byte loads.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
    issue(1'b1, 32'h11, 32'h80, 3'b000, 1'b1);
    issue(1'b0, 32'h11, 32'h0, 3'b000, 1'b1);
    issue(1'b0, 32'h11, 32'h0, 3'b100, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);

    // Long response stall.
    issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
    hold_cnt = 5;

    // Illegal width codes.
    issue(1'b0, 32'h10, 32'h0, 3'b011, 1'b1);
    issue(1'b1, 32'h20, 32'h12345678, 3'b100, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b1);

    // Reset during the wait phase of a store: store must be lost.
    issue(1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("async_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    exp_q.delete();
    hold_cnt = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset2", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, 32'h30, 32'h0, 3'b010, 1'b1);

    // Odd halfword address, aliasing beyond the array, upper halfword loads.
    issue(1'b0, 32'h13, 32'h0, 3'b001, 1'b1);
    issue(1'b1, 32'h400, 32'hA5A55A5A, 3'b010, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 3'b010, 1'b1);
    issue(1'b0, 32'h12, 32'h0, 3'b101, 1'b1);
    issue(1'b0, 32'h2, 32'h0, 3'b001, 1'b1);

    // Random traffic across all widths, codes and full 32-bit addresses.
    repeat (300) begin
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
    end

    n = 0;
    while ((exp_q.size() != 0 || in_resp) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", {31'd0, in_resp}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
